// File: rtl/tangcore_host.sv
// tangcore_host: MCU-side engine for the TangCore companion UART protocol.
// Turns parallel commands into command frames (opcode, argument bytes,
// optional payload) on a byte stream toward a UART transmitter. Independently
// parses reply frames coming back from the core's UART receiver.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   cmd_valid/cmd_ready/op/arg      command handshake (ready while IDLE)
//   data_in/_valid/_ready           payload stream for op 5 / op 7
//   tx_byte/tx_valid/tx_ready       byte stream to UART TX
//   rx_byte/rx_valid                1-cycle byte strobe from UART RX
//   core_id/core_id_valid           core ID reply
//   cfg_char/_valid, cfg_done       config string characters and terminator
//   joy1/joy2/joy_update            joypad state
//   busy                            TX FSM not idle
//   err                             invalid op, reply timeout or string overflow
module tangcore_host #(
  parameter int RESP_TIMEOUT = 1_000_000,
  parameter int STR_MAX      = 128
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  core_id,
  output logic        core_id_valid,
  output logic [7:0]  cfg_char,
  output logic        cfg_char_valid,
  output logic        cfg_done,
  output logic [15:0] joy1,
  output logic [15:0] joy2,
  output logic        joy_update,
  output logic        busy,
  output logic        err
);

  localparam int          SCW      = $clog2(STR_MAX + 1);
  localparam logic [SCW-1:0] SMAX  = SCW'(STR_MAX);
  localparam logic [31:0] TMO_LAST = 32'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_OPCODE, S_ARGS, S_PAYLOAD, S_WAIT} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_JOY, R_ID, R_STR} rx_state_e;

  tx_state_e   state_q;
  logic [3:0]  op_q;
  logic [31:0] arg_q;
  logic [1:0]  idx_q;
  logic [23:0] cnt_q;
  logic [31:0] tmo_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q, busy_q, err_q;

  rx_state_e   rstate_q;
  logic [1:0]  jcnt_q;
  logic [7:0]  b1_q, b2_q, b3_q;
  logic [SCW-1:0] scnt_q;
  logic [7:0]  core_id_q, cfg_char_q;
  logic [15:0] joy1_q, joy2_q;
  logic        core_id_valid_q, cfg_char_valid_q, cfg_done_q, joy_update_q, ovf_q;

  // Number of argument bytes following the opcode.
  function automatic logic [2:0] n_args(input logic [3:0] op);
    case (op)
      4'd3, 4'd9: n_args = 3'd4;
      4'd4:       n_args = 3'd2;
      4'd7:       n_args = 3'd3;
      4'd6, 4'd8: n_args = 3'd1;
      default:    n_args = 3'd0;
    endcase
  endfunction

  // Byte lane of arg sent as argument byte idx (op 9 is little-endian per pair,
  // the others send the most significant used byte first).
  function automatic logic [7:0] arg_byte(input logic [3:0] op, input logic [31:0] arg,
                                          input logic [1:0] idx);
    logic [1:0] bi;
    case (op)
      4'd3:    bi = 2'd3 - idx;
      4'd4:    bi = 2'd1 - idx;
      4'd7:    bi = 2'd2 - idx;
      4'd9:    bi = idx;
      default: bi = 2'd0;
    endcase
    arg_byte = arg[{bi, 3'b000} +: 8];
  endfunction

  // The (STR_MAX+1)-th nonzero character of a config string.
  logic rx_ovf_c;
  assign rx_ovf_c = rx_valid && (rstate_q == R_STR) && (rx_byte != 8'h00) && (scnt_q == SMAX);

  // Reply completion is taken from the registered RX pulses.
  logic resp_done;
  assign resp_done = (op_q == 4'd1) ? core_id_valid_q : (cfg_done_q | ovf_q);

  assign cmd_ready     = (state_q == S_IDLE);
  assign data_in_ready = (state_q == S_PAYLOAD) && !tx_valid_q;

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      arg_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= rx_ovf_c;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            arg_q <= cmd_arg;
            if (cmd_op == 4'd0 || cmd_op > 4'd9) begin
              err_q <= 1'b1;
            end else begin
              tx_byte_q  <= {4'h0, cmd_op};
              tx_valid_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_OPCODE;
            end
          end
        end
        S_OPCODE: begin
          if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
            idx_q      <= '0;
            tmo_q      <= '0;
            if (n_args(op_q) != 3'd0)             state_q <= S_ARGS;
            else if (op_q == 4'd5)                state_q <= S_PAYLOAD;
            else if (op_q == 4'd1 || op_q == 4'd2) state_q <= S_WAIT;
            else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_ARGS: begin
          // One idle cycle between bytes: present only while tx_valid is low.
          if (!tx_valid_q) begin
            tx_byte_q  <= arg_byte(op_q, arg_q, idx_q);
            tx_valid_q <= 1'b1;
          end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
            if ({1'b0, idx_q} == n_args(op_q) - 3'd1) begin
              if (op_q == 4'd7 && arg_q[23:0] != 24'd0) begin
                cnt_q   <= arg_q[23:0];
                state_q <= S_PAYLOAD;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (!tx_valid_q) begin
            if (data_in_valid) begin
              tx_byte_q  <= data_in;
              tx_valid_q <= 1'b1;
            end
          end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
            cnt_q      <= cnt_q - 24'd1;
            // op 5 ends after its 0x00 terminator, op 7 after len bytes.
            if ((op_q == 4'd5) ? (tx_byte_q == 8'h00) : (cnt_q == 24'd1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          // Completion is checked first so it beats a same-cycle expiry.
          if (resp_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- RX parser ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q         <= R_IDLE;
      jcnt_q           <= '0;
      b1_q             <= '0;
      b2_q             <= '0;
      b3_q             <= '0;
      scnt_q           <= '0;
      core_id_q        <= '0;
      cfg_char_q       <= '0;
      joy1_q           <= '0;
      joy2_q           <= '0;
      core_id_valid_q  <= 1'b0;
      cfg_char_valid_q <= 1'b0;
      cfg_done_q       <= 1'b0;
      joy_update_q     <= 1'b0;
      ovf_q            <= 1'b0;
    end else begin
      core_id_valid_q  <= 1'b0;
      cfg_char_valid_q <= 1'b0;
      cfg_done_q       <= 1'b0;
      joy_update_q     <= 1'b0;
      ovf_q            <= 1'b0;
      if (rx_valid) begin
        case (rstate_q)
          R_IDLE: begin
            case (rx_byte)
              8'h01: begin rstate_q <= R_JOY; jcnt_q <= '0; end
              8'h11: rstate_q <= R_ID;
              8'h22: begin rstate_q <= R_STR; scnt_q <= '0; end
              default: ;
            endcase
          end
          R_JOY: begin
            jcnt_q <= jcnt_q + 2'd1;
            case (jcnt_q)
              2'd0: b1_q <= rx_byte;
              2'd1: b2_q <= rx_byte;
              2'd2: b3_q <= rx_byte;
              default: begin
                // Both pads commit together so a partial frame is never visible.
                joy1_q       <= {b2_q, b1_q};
                joy2_q       <= {rx_byte, b3_q};
                joy_update_q <= 1'b1;
                rstate_q     <= R_IDLE;
              end
            endcase
          end
          R_ID: begin
            core_id_q       <= rx_byte;
            core_id_valid_q <= 1'b1;
            rstate_q        <= R_IDLE;
          end
          R_STR: begin
            if (rx_byte == 8'h00) begin
              cfg_done_q <= 1'b1;
              rstate_q   <= R_IDLE;
            end else if (rx_ovf_c) begin
              ovf_q    <= 1'b1;
              rstate_q <= R_IDLE;
            end else begin
              cfg_char_q       <= rx_byte;
              cfg_char_valid_q <= 1'b1;
              scnt_q           <= scnt_q + 1'b1;
            end
          end
          default: rstate_q <= R_IDLE;
        endcase
      end
    end
  end

  assign tx_byte        = tx_byte_q;
  assign tx_valid       = tx_valid_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign core_id        = core_id_q;
  assign core_id_valid  = core_id_valid_q;
  assign cfg_char       = cfg_char_q;
  assign cfg_char_valid = cfg_char_valid_q;
  assign cfg_done       = cfg_done_q;
  assign joy1           = joy1_q;
  assign joy2           = joy2_q;
  assign joy_update     = joy_update_q;

endmodule

// File: tb/tb_tangcore_host.sv
// Self-checking bench for tangcore_host: directed protocol scenarios plus
// randomized command and reply streams compared against a byte-list model.
module tb_tangcore_host;
  localparam int TMO  = 100;
  localparam int SMAX = 8;

  logic        clk, resetn;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [7:0]  data_in;
  logic        data_in_valid, data_in_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  core_id, cfg_char;
  logic        core_id_valid, cfg_char_valid, cfg_done;
  logic [15:0] joy1, joy2;
  logic        joy_update, busy, err;

  tangcore_host #(.RESP_TIMEOUT(TMO), .STR_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .core_id(core_id), .core_id_valid(core_id_valid),
    .cfg_char(cfg_char), .cfg_char_valid(cfg_char_valid), .cfg_done(cfg_done),
    .joy1(joy1), .joy2(joy2), .joy_update(joy_update),
    .busy(busy), .err(err)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int checks = 0, errors = 0;
  logic [7:0]  cap[$], exp_tx[$], pq[$], rxs[$];
  logic [7:0]  id_q[$], exp_id[$], chr_q[$], exp_chr[$];
  logic [31:0] joy_q[$], exp_joy[$];
  int done_n = 0, exp_done = 0, err_n = 0, exp_err = 0;
  int cyc = 0, hs_cyc = 0, err_cyc = 0, stab_bad = 0, tog = 0, tx_mode = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // tx_ready pattern: 0 always ready, 1 toggles every 3 cycles, 2 random, 3 stalled.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tog++;
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ((tog / 3) % 2) == 0;
        2: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Observer: records everything the DUT emits.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_hold && tx_valid && tx_byte !== prev_byte) stab_bad++;
      prev_hold = tx_valid && !tx_ready;
      prev_byte = tx_byte;
      if (tx_valid && tx_ready) begin cap.push_back(tx_byte); hs_cyc = cyc; end
      if (joy_update)     joy_q.push_back({joy1, joy2});
      if (core_id_valid)  id_q.push_back(core_id);
      if (cfg_char_valid) chr_q.push_back(cfg_char);
      if (cfg_done)       done_n++;
      if (err) begin err_n++; err_cyc = cyc; end
    end
  end

  // Expected frame on the wire; payload comes from pq.
  task automatic model_tx(input logic [3:0] op, input logic [31:0] a);
    if (op == 4'd0 || op > 4'd9) return;
    exp_tx.push_back({4'h0, op});
    case (op)
      4'd3: for (int i = 3; i >= 0; i--) exp_tx.push_back(a[8*i +: 8]);
      4'd4: begin exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]); end
      4'd6, 4'd8: exp_tx.push_back(a[7:0]);
      4'd7: begin
        exp_tx.push_back(a[23:16]); exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]);
        foreach (pq[i]) exp_tx.push_back(pq[i]);
      end
      4'd9: for (int i = 0; i < 4; i++) exp_tx.push_back(a[8*i +: 8]);
      4'd5: foreach (pq[i]) exp_tx.push_back(pq[i]);
      default: ;
    endcase
  endtask

  // Expected reply events for the byte stream in rxs.
  task automatic model_rx();
    int i = 0;
    int n;
    logic [7:0] c;
    while (i < rxs.size()) begin
      c = rxs[i]; i++;
      if (c == 8'h01 && i + 4 <= rxs.size()) begin
        exp_joy.push_back({rxs[i+1], rxs[i], rxs[i+3], rxs[i+2]});
        i += 4;
      end else if (c == 8'h11 && i < rxs.size()) begin
        exp_id.push_back(rxs[i]); i++;
      end else if (c == 8'h22) begin
        n = 0;
        while (i < rxs.size()) begin
          c = rxs[i]; i++;
          if (c == 8'h00) begin exp_done++; break; end
          if (n == SMAX) begin exp_err++; break; end
          exp_chr.push_back(c); n++;
        end
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) check("issue_timeout", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = a;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed();
    int n = 0;
    while (pq.size() > 0 && n < 2000) begin
      @(posedge clk); #1;
      data_in_valid = 1'b1; data_in = pq[0];
      @(negedge clk);
      if (data_in_ready) void'(pq.pop_front());
      n++;
    end
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    check("feed_drained", pq.size(), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cmd_ready && !tx_valid) && n < 5000) begin @(posedge clk); #1; n++; end
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic rx_burst();
    foreach (rxs[i]) begin
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_byte = rxs[i];
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic cmp_tx(input string tag);
    check({tag, "_len"}, cap.size(), exp_tx.size());
    foreach (exp_tx[i]) if (i < cap.size()) check({tag, "_byte"}, cap[i], exp_tx[i]);
    cap.delete(); exp_tx.delete();
  endtask

  task automatic cmp_rx(input string tag);
    check({tag, "_joy_n"}, joy_q.size(), exp_joy.size());
    foreach (exp_joy[i]) if (i < joy_q.size()) check({tag, "_joy"}, joy_q[i], exp_joy[i]);
    check({tag, "_id_n"}, id_q.size(), exp_id.size());
    foreach (exp_id[i]) if (i < id_q.size()) check({tag, "_id"}, id_q[i], exp_id[i]);
    check({tag, "_chr_n"}, chr_q.size(), exp_chr.size());
    foreach (exp_chr[i]) if (i < chr_q.size()) check({tag, "_chr"}, chr_q[i], exp_chr[i]);
    check({tag, "_done_n"}, done_n, exp_done);
    check({tag, "_err_n"}, err_n, exp_err);
    joy_q.delete(); exp_joy.delete(); id_q.delete(); exp_id.delete();
    chr_q.delete(); exp_chr.delete();
  endtask

  function automatic logic [7:0] plain_byte();
    logic [7:0] v;
    do v = 8'($urandom_range(1, 255)); while (v == 8'h01 || v == 8'h11 || v == 8'h22);
    return v;
  endfunction

  task automatic gen_rx(input int frames);
    int k;
    rxs.delete();
    repeat (frames) begin
      case ($urandom_range(0, 3))
        0: rxs.push_back(plain_byte());
        1: begin rxs.push_back(8'h01); repeat (4) rxs.push_back(8'($urandom)); end
        2: begin rxs.push_back(8'h11); rxs.push_back(8'($urandom)); end
        default: begin
          rxs.push_back(8'h22);
          k = $urandom_range(0, SMAX + 2);
          repeat (k) rxs.push_back(plain_byte());
          rxs.push_back(8'h00);
        end
      endcase
    end
  endtask

  logic [3:0]  op;
  logic [31:0] a;
  logic [3:0]  ops [7] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  logic [3:0]  bad [2] = '{4'd0, 4'hC};
  int n, k;

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    data_in = '0; data_in_valid = 1'b0; rx_byte = '0; rx_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_joy", {joy1, joy2}, 0);
    check("rst_din_ready", data_in_ready, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // op 3, always ready
    tx_mode = 0;
    pq.delete(); model_tx(4'd3, 32'h12345678);
    issue(4'd3, 32'h12345678);
    check("op3_opcode_next", {tx_valid, tx_byte}, {1'b1, 8'h03});
    check("op3_busy", busy, 1);
    check("op3_cmd_ready_low", cmd_ready, 0);
    wait_idle(); cmp_tx("op3");

    // op 7 with backpressure, then len 0
    tx_mode = 1;
    pq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    model_tx(4'd7, 32'd5);
    issue(4'd7, 32'd5); feed(); wait_idle(); cmp_tx("op7");
    pq.delete(); model_tx(4'd7, 32'd0);
    issue(4'd7, 32'd0); wait_idle(); cmp_tx("op7_len0");

    // randomized commands with random backpressure
    tx_mode = 2;
    repeat (14) begin
      op = ops[$urandom_range(0, 6)];
      a = $urandom;
      pq.delete();
      if (op == 4'd7) begin
        a[23:0] = 24'($urandom_range(0, 6));
        repeat (int'(a[23:0])) pq.push_back(8'($urandom));
      end
      if (op == 4'd5) begin
        k = $urandom_range(0, 5);
        repeat (k) pq.push_back(8'($urandom_range(1, 255)));
        pq.push_back(8'h00);
      end
      model_tx(op, a);
      issue(op, a);
      if (pq.size() > 0) feed();
      wait_idle(); cmp_tx("rand_tx");
    end

    // op 2 with a joypad frame arriving during the wait
    tx_mode = 0;
    pq.delete(); model_tx(4'd2, 32'd0);
    issue(4'd2, 32'd0);
    rxs = '{8'h01, 8'h34, 8'h12, 8'h78, 8'h56, 8'h22, 8'h54, 8'h61, 8'h00};
    model_rx(); rx_burst();
    wait_idle(); cmp_tx("op2");
    check("op2_joy1", joy1, 16'h1234);
    check("op2_joy2", joy2, 16'h5678);
    cmp_rx("op2");

    // op 1 answered
    pq.delete(); model_tx(4'd1, 32'd0);
    issue(4'd1, 32'd0);
    rxs = '{8'h11, 8'h02};
    model_rx(); rx_burst();
    check("op1_id_pulse", core_id_valid, 1);
    check("op1_core_id", core_id, 8'h02);
    wait_idle(); cmp_tx("op1"); cmp_rx("op1");

    // op 1 unanswered: err exactly TMO cycles after the opcode handshake
    k = err_n;
    pq.delete(); model_tx(4'd1, 32'd0);
    issue(4'd1, 32'd0);
    n = 0;
    while (err_n == k && n < 4 * TMO) begin @(posedge clk); #1; n++; end
    check("tmo_err_seen", err_n, k + 1);
    check("tmo_cycle", err_cyc - hs_cyc, TMO + 1);
    exp_err++;
    wait_idle(); cmp_tx("op1_tmo"); cmp_rx("op1_tmo");

    // invalid opcodes
    foreach (bad[i]) begin
      issue(bad[i], $urandom);
      check("inv_err", err, 1);
      check("inv_tx_valid", tx_valid, 0);
      check("inv_busy", busy, 0);
      check("inv_cmd_ready", cmd_ready, 1);
      exp_err++;
      repeat (3) @(posedge clk); #1;
      cmp_tx("inv");
    end
    cmp_rx("inv");

    // config string overflow
    rxs = '{8'h22, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h00};
    model_rx(); rx_burst();
    repeat (2) @(posedge clk); #1;
    cmp_rx("ovf");

    // random back-to-back reply streams
    repeat (5) begin
      gen_rx(6); model_rx(); rx_burst();
      repeat (2) @(posedge clk); #1;
      cmp_rx("rand_rx");
    end

    // reset while the second payload byte of op 5 is on the wire
    tx_mode = 0;
    cap.delete(); exp_tx.delete();
    issue(4'd5, 32'd0);
    data_in = 8'h41; data_in_valid = 1'b1;
    n = 0;
    while (cap.size() < 2 && n < 200) begin @(posedge clk); #2; n++; end
    while (!tx_valid && n < 200) begin @(posedge clk); #2; n++; end
    check("mid_second_byte", tx_valid, 1);
    resetn = 1'b0; #1;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_tx_byte", tx_byte, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_din_ready", data_in_ready, 0);
    check("mid_rst_outs", {joy1, joy2, core_id, cfg_char}, 0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    cap.delete();
    pq.delete(); model_tx(4'd8, 32'h01);
    issue(4'd8, 32'h01); wait_idle(); cmp_tx("op8_after_rst");

    check("tx_byte_stable", stab_bad, 0);
    cmp_rx("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tangcore_host.md
# tangcore_host

Host-side engine for the TangCore companion UART protocol: it plays the MCU role toward a core's IO system. It serializes parallel commands into command frames, streams ROM and string payloads, and parses the core's reply frames (core ID, config string, joypad state). It sits between a loader/menu controller and a byte-level UART transmitter/receiver pair. Typical uses are boards without the companion MCU and self-checking loopback benches.

## Interface
- `RESP_TIMEOUT`, default 1_000_000: cycles to wait for the reply to op 1/2, counted from the opcode byte handshake.
- `STR_MAX`, default 128: maximum accepted config string characters, excluding the terminator.
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake. A command is accepted when both are high.
- `cmd_op` in 4: opcode 1..9.
- `cmd_arg` in 32: argument. Meaning depends on the opcode (see Operation).
- `data_in` in 8 / `data_in_valid` in 1 / `data_in_ready` out 1: payload stream for op 5 and op 7.
- `tx_byte` out 8 / `tx_valid` out 1 / `tx_ready` in 1: byte stream to the UART transmitter.
- `rx_byte` in 8 / `rx_valid` in 1: 1-cycle byte strobe from the UART receiver.
- `core_id` out 8 / `core_id_valid` out 1: received core ID and its pulse.
- `cfg_char` out 8 / `cfg_char_valid` out 1 / `cfg_done` out 1: config string characters, one pulse per character, and an end-of-string pulse.
- `joy1` out 16 / `joy2` out 16 / `joy_update` out 1: latest joypad state and its update pulse.
- `busy` out 1: the TX FSM is not in IDLE.
- `err` out 1: 1-cycle pulse on an invalid op, a reply timeout, or string overflow.

## Operation
**TX FSM.** States are IDLE → OPCODE → ARGS → PAYLOAD → WAIT_RESP → IDLE. States with nothing to do are skipped.
- `cmd_ready` = (state == IDLE).
- On accept, latch `cmd_op` and `cmd_arg`, then send the opcode byte.
- Argument bytes per opcode:
  - op 1, op 2: none.
  - op 3: 4 bytes, `arg[31:24]` first.
  - op 4: `arg[15:8]` (x), then `arg[7:0]` (y).
  - op 5: none.
  - op 6: `arg[7:0]`.
  - op 7: `arg[23:16]`, `arg[15:8]`, `arg[7:0]` (length).
  - op 8: `arg[7:0]`.
  - op 9: `arg[7:0]`, `arg[15:8]`, `arg[23:16]`, `arg[31:24]` (hid1 low/high, hid2 low/high).
- Payload:
  - op 5 forwards `data_in` bytes up to and including the first 0x00, then returns to IDLE.
  - op 7 forwards exactly `len` bytes using a 24-bit down-counter. `len` = 0 skips PAYLOAD.
- Op 1/2: after the opcode handshake, enter WAIT_RESP.
  - Op 1 leaves on `core_id_valid`; op 2 leaves on `cfg_done` or string overflow.
  - Otherwise leave when the timeout counter reaches `RESP_TIMEOUT`, pulsing `err`.
  - If completion and expiry occur in the same cycle, completion wins and there is no `err`.
- Op 0 or op > 9: accepted, nothing sent, `err` pulses, stays IDLE.

**RX parser.** Runs independently of the TX FSM, in every TX state. Its states are R_IDLE, R_JOY, R_ID and R_STR.
- In R_IDLE: 0x01 → R_JOY (4 bytes); 0x11 → R_ID (1 byte); 0x22 → R_STR. Any other byte is dropped.
- R_JOY: bytes b1..b4. On b4, `joy1`={b2,b1}, `joy2`={b4,b3} and `joy_update` pulse together; partial frames never show on the outputs.
- R_ID: `core_id` ← byte, `core_id_valid` pulses.
- R_STR:
  - A nonzero byte gives a `cfg_char_valid` pulse.
  - 0x00 gives a `cfg_done` pulse and a return to R_IDLE.
  - The (`STR_MAX`+1)-th nonzero character is not emitted; `err` pulses and the parser returns to R_IDLE with no `cfg_done`.
- Joypad frames arriving during WAIT_RESP are parsed normally.

**Reset.** Asserting `resetn` low, including mid-frame, clears every state, counter and output to 0 immediately. A partially sent frame is abandoned.

## Timing
- All outputs are registered except `cmd_ready` and `data_in_ready`.
- Output values under reset: `tx_byte`, `tx_valid`, `core_id`, `cfg_char`, `joy1`, `joy2` and all pulses are 0; `busy` is 0; `cmd_ready` is 1.
- TX path:
  - The opcode appears on `tx_valid`/`tx_byte` the cycle after command accept.
  - A byte transfers on `tx_valid && tx_ready`.
  - `tx_byte` stays stable while `tx_valid` is high and unacknowledged.
  - The next byte is presented no earlier than the cycle after the handshake, so at most 1 byte per 2 cycles.
- Payload path:
  - `data_in_ready` = (state == PAYLOAD) && !`tx_valid`.
  - An accepted byte drives `tx_byte` the next cycle.
- RX path:
  - Pulses (`core_id_valid`, `cfg_char_valid`, `cfg_done`, `joy_update`) are 1 cycle wide, one cycle after the qualifying `rx_valid`.
  - Pulses from back-to-back `rx_valid` cycles must all be produced.
- `busy` is high from the cycle after accept until the cycle IDLE is re-entered.

## Test plan
- **Op 3:** op 3 with arg 0x12345678, `tx_ready` always 1 → bytes 03 12 34 56 78, then `cmd_ready` high again.
- **Op 7 + backpressure:** op 7, len 5, payload A0..A4, `tx_ready` toggling every 3 cycles → 07 00 00 05 A0 A1 A2 A3 A4 with no byte dropped or duplicated. A follow-up op 7 with len 0 → only 07 00 00 00.
- **Op 2 with interleaved joypad:** op 2, rx 01 34 12 78 56 then 22 'T' 'a' 00 → `joy1`=0x1234, `joy2`=0x5678 with one `joy_update`; `cfg_char` 'T', 'a'; then `cfg_done`; then IDLE with no `err`.
- **Op 1:**
  - With rx 11 02 → `core_id`=0x02 and IDLE.
  - With no reply and `RESP_TIMEOUT`=100 → `err` on cycle 100 after the opcode handshake.
- **Invalid op / overflow:**
  - Op 0x0C → `err`, no tx bytes.
  - Config string of `STR_MAX`+1 characters → `STR_MAX` `cfg_char` pulses, `err`, no `cfg_done`.
- **Reset mid-frame:** `resetn` low during the second payload byte of op 5 → all outputs 0 immediately. After release, a new op 8 with arg 0x01 sends 08 01.
